// File: rtl/public_test_pack.sv
// Packs DEPTH consecutive N-bit test-output words into one frame behind valid/ready handshakes.
// Define PUBLIC_TEST_PACK_PARITY_EN to add the per-frame XOR on pack_parity (otherwise tied to 0).
module public_test_pack #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_valid,
    input  logic [N-1:0]         d_in,
    output logic                 d_ready,
    output logic                 pack_valid,
    input  logic                 pack_ready,
    output logic [N*DEPTH-1:0]   pack_out,
    output logic [7:0]           frame_cnt,
    output logic [N-1:0]         pack_parity
);

    localparam int unsigned     IdxW    = $clog2(DEPTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DEPTH - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    localparam logic [0:0] StFill = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [N*DEPTH-1:0] slots_q, slots_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               accept;

    // In HOLD a word can only enter alongside the handoff that frees the frame.
    assign d_ready    = (state_q == StFill) ? 1'b1 : pack_ready;
    assign accept     = d_valid & d_ready;
    assign pack_valid = (state_q == StHold);
    assign pack_out   = slots_q;
    assign frame_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slots_d = slots_q;
        cnt_d   = cnt_q;
        case (state_q)
            StFill: begin
                if (accept) begin
                    slots_d[int'(idx_q)*N +: N] = d_in;
                    if (idx_q == IdxLast) begin
                        idx_d   = '0;
                        state_d = StHold;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (pack_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = StFill;
                    if (d_valid) begin
                        slots_d[N-1:0] = d_in;
                        idx_d          = IdxOne;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            idx_q   <= '0;
            slots_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slots_q <= slots_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PUBLIC_TEST_PACK_PARITY_EN
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] par_q, par_d;

    // The accumulator is already zero in HOLD, so a handoff word simply seeds it.
    always_comb begin
        acc_d = acc_q;
        par_d = par_q;
        if (state_q == StFill) begin
            if (accept) begin
                if (idx_q == IdxLast) begin
                    par_d = acc_q ^ d_in;
                    acc_d = '0;
                end else begin
                    acc_d = acc_q ^ d_in;
                end
            end
        end else if (pack_ready) begin
            acc_d = d_valid ? d_in : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            par_q <= '0;
        end else begin
            acc_q <= acc_d;
            par_q <= par_d;
        end
    end

    assign pack_parity = par_q;
`else
    assign pack_parity = '0;
`endif

endmodule

// File: tb/tb_public_test_pack.sv
// Directed self-checking bench for public_test_pack with N=8, DEPTH=4.
module tb_public_test_pack;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 4;

    logic                clk;
    logic                rst;
    logic                d_valid;
    logic [N-1:0]        d_in;
    logic                d_ready;
    logic                pack_valid;
    logic                pack_ready;
    logic [N*DEPTH-1:0]  pack_out;
    logic [7:0]          frame_cnt;
    logic [N-1:0]        pack_parity;

    int checks = 0;
    int errors = 0;

    public_test_pack #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_valid     (d_valid),
        .d_in        (d_in),
        .d_ready     (d_ready),
        .pack_valid  (pack_valid),
        .pack_ready  (pack_ready),
        .pack_out    (pack_out),
        .frame_cnt   (frame_cnt),
        .pack_parity (pack_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end (got running, want finished)");
        $fatal(1, "timeout");
    end

    function automatic logic [N-1:0] exp_par(input logic [N-1:0] p);
`ifdef PUBLIC_TEST_PACK_PARITY_EN
        return p;
`else
        return '0;
`endif
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        d_valid    = 1'b0;
        d_in       = '0;
        pack_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic send(input logic [N-1:0] w);
        d_valid = 1'b1;
        d_in    = w;
        cycle();
        d_valid = 1'b0;
        d_in    = 8'hEE;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pack_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", pack_valid); end
        checks++; if (pack_out !== 32'h0) begin errors++;
            $display("FAIL reset_out: got %h want 00000000", pack_out); end
        checks++; if (frame_cnt !== 8'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        checks++; if (pack_parity !== 8'h00) begin errors++;
            $display("FAIL reset_parity: got %h want 00", pack_parity); end
        checks++; if (d_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b want 1", d_ready); end
    endtask

    task automatic fill_basic();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        checks++; if (pack_valid !== 1'b0) begin errors++;
            $display("FAIL basic_early_valid: got %b want 0", pack_valid); end
        send(8'h44);
    endtask

    task automatic test_basic_frame();
        do_reset();
        fill_basic();
        checks++; if (pack_valid !== 1'b1) begin errors++;
            $display("FAIL basic_valid: got %b want 1", pack_valid); end
        checks++; if (pack_out !== 32'h44332211) begin errors++;
            $display("FAIL basic_out: got %h want 44332211", pack_out); end
        checks++; if (d_ready !== 1'b0) begin errors++;
            $display("FAIL basic_ready: got %b want 0", d_ready); end
        checks++; if (pack_parity !== exp_par(8'h44)) begin errors++;
            $display("FAIL basic_parity: got %h want %h", pack_parity, exp_par(8'h44)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_basic();
        d_valid = 1'b1;
        d_in    = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++; if (pack_out !== 32'h44332211 || pack_valid !== 1'b1) begin errors++;
                $display("FAIL bp_hold: got %h/%b want 44332211/1", pack_out, pack_valid); end
        end
        checks++; if (frame_cnt !== 8'd0) begin errors++;
            $display("FAIL bp_cnt_hold: got %0d want 0", frame_cnt); end
        d_valid    = 1'b0;
        pack_ready = 1'b1;
        #1;
        checks++; if (d_ready !== 1'b1) begin errors++;
            $display("FAIL bp_ready_follow: got %b want 1", d_ready); end
        cycle();
        pack_ready = 1'b0;
        checks++; if (frame_cnt !== 8'd1) begin errors++;
            $display("FAIL bp_cnt: got %0d want 1", frame_cnt); end
        checks++; if (pack_valid !== 1'b0) begin errors++;
            $display("FAIL bp_valid_fall: got %b want 0", pack_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        pack_ready = 1'b1;
        send(8'hA5);
        pack_ready = 1'b0;
        checks++; if (frame_cnt !== 8'd1 || pack_valid !== 1'b0) begin errors++;
            $display("FAIL sim_handoff: got cnt %0d valid %b want 1/0", frame_cnt, pack_valid); end
        send(8'hB6);
        send(8'hC7);
        checks++; if (pack_valid !== 1'b0) begin errors++;
            $display("FAIL sim_early_valid: got %b want 0", pack_valid); end
        send(8'hD8);
        checks++; if (pack_valid !== 1'b1) begin errors++;
            $display("FAIL sim_valid: got %b want 1", pack_valid); end
        checks++; if (pack_out !== 32'hD8C7B6A5) begin errors++;
            $display("FAIL sim_out: got %h want D8C7B6A5", pack_out); end
        checks++; if (frame_cnt !== 8'd1) begin errors++;
            $display("FAIL sim_cnt: got %0d want 1", frame_cnt); end
        checks++; if (pack_parity !== exp_par(8'h0C)) begin errors++;
            $display("FAIL sim_parity: got %h want %h", pack_parity, exp_par(8'h0C)); end
    endtask

    task automatic test_gapped();
        logic [8:0] vec [7];
        vec = '{9'h101, 9'h0EE, 9'h0EE, 9'h102, 9'h103, 9'h0EE, 9'h104};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            checks++; if (pack_valid !== 1'b0) begin errors++;
                $display("FAIL gap_valid_%0d: got %b want 0", i, pack_valid); end
            d_valid = vec[i][8];
            d_in    = vec[i][7:0];
            cycle();
        end
        d_valid = 1'b0;
        checks++; if (pack_valid !== 1'b1) begin errors++;
            $display("FAIL gap_valid: got %b want 1", pack_valid); end
        checks++; if (pack_out !== 32'h04030201) begin errors++;
            $display("FAIL gap_out: got %h want 04030201", pack_out); end
        checks++; if (pack_parity !== exp_par(8'h04)) begin errors++;
            $display("FAIL gap_parity: got %h want %h", pack_parity, exp_par(8'h04)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h10);
        send(8'h20);
        rst     = 1'b1;
        d_valid = 1'b1;
        d_in    = 8'h99;
        cycle();
        rst     = 1'b0;
        d_valid = 1'b0;
        checks++; if (pack_out !== 32'h0 || frame_cnt !== 8'd0) begin errors++;
            $display("FAIL mid_rst_clear: got %h/%0d want 00000000/0", pack_out, frame_cnt); end
        send(8'h30); send(8'h40); send(8'h50); send(8'h60);
        checks++; if (pack_valid !== 1'b1 || pack_out !== 32'h60504030) begin errors++;
            $display("FAIL mid_out: got %h/%b want 60504030/1", pack_out, pack_valid); end
        checks++; if (frame_cnt !== 8'd0) begin errors++;
            $display("FAIL mid_cnt: got %0d want 0", frame_cnt); end
        checks++; if (pack_parity !== exp_par(8'h40)) begin errors++;
            $display("FAIL mid_parity: got %h want %h", pack_parity, exp_par(8'h40)); end
        // Reset in HOLD with a handoff offered must drop the frame without counting it.
        rst        = 1'b1;
        pack_ready = 1'b1;
        cycle();
        rst        = 1'b0;
        pack_ready = 1'b0;
        checks++; if (pack_valid !== 1'b0 || frame_cnt !== 8'd0) begin errors++;
            $display("FAIL hold_rst: got %b/%0d want 0/0", pack_valid, frame_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0]  cnt_exp;
        logic        val_exp;
        logic [31:0] out_exp;
        int          f;
        do_reset();
        pack_ready = 1'b1;
        d_valid    = 1'b1;
        for (int e = 1; e <= 1025; e++) begin
            d_in = 8'(e - 1);
            cycle();
            cnt_exp = 8'(((e - 1) / 4) % 256);
            val_exp = (e % 4 == 0);
            checks++; if (pack_valid !== val_exp || frame_cnt !== cnt_exp) begin errors++;
                $display("FAIL wrap_e%0d: got valid %b cnt %0d want %b %0d",
                         e, pack_valid, frame_cnt, val_exp, cnt_exp); end
            if (val_exp) begin
                f = e / 4 - 1;
                out_exp = {8'(4*f+3), 8'(4*f+2), 8'(4*f+1), 8'(4*f)};
                checks++; if (pack_out !== out_exp || pack_parity !== 8'h00) begin errors++;
                    $display("FAIL wrap_frame%0d: got %h/%h want %h/00",
                             f, pack_out, pack_parity, out_exp); end
            end
        end
        d_valid    = 1'b0;
        pack_ready = 1'b0;
        checks++; if (frame_cnt !== 8'd0) begin errors++;
            $display("FAIL wrap_final: got %0d want 0", frame_cnt); end
    endtask

    initial begin
        rst        = 1'b1;
        d_valid    = 1'b0;
        d_in       = '0;
        pack_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_simultaneous();
        test_gapped();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/public_test_pack.md
# public_test_pack

Downstream collector for the per-cycle 8-bit public test output stream. Each clock cycle the test circuit produces one output word. This block accepts those words under a valid/ready handshake and packs DEPTH consecutive words into one frame. It presents the frame under a second valid/ready handshake and counts completed frames. It sits directly after the public test circuit's `o` output and feeds the result sink.

## Interface
- N, 8, width of one input word (matches the test circuit output width)
- DEPTH, 4, words per frame; legal range 2..16
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- d_valid  input  1  d_in carries a word this cycle
- d_in  input  N  output word from the public test circuit
- d_ready  output  1  block accepts a word this cycle; combinational
- pack_valid  output  1  pack_out holds a complete frame; registered
- pack_ready  input  1  downstream consumes the frame this cycle
- pack_out  output  N*DEPTH  frame; word k at bits [N*k+N-1 : N*k], word 0 = first accepted
- frame_cnt  output  8  completed frames handed off; wraps modulo 256
- pack_parity  output  N  XOR of the frame's words; present only with the macro (see Configuration)

## Operation
- A word is accepted on a cycle where d_valid and d_ready are both 1. A frame is handed off on a cycle where pack_valid and pack_ready are both 1.
- FSM has two states, FILL and HOLD. Word index idx runs 0..DEPTH-1, width clog2(DEPTH).
- FILL:
  - d_ready = 1, pack_valid = 0.
  - An accepted word is written to slot idx, and idx increments.
  - Accepting a word at idx = DEPTH-1 sets idx to 0 and moves the FSM to HOLD.
  - When d_valid = 0, idx and slots hold.
- HOLD:
  - pack_valid = 1. pack_out and pack_parity are stable.
  - d_ready = pack_ready.
  - On handoff, frame_cnt increments (255 -> 0) and the FSM returns to FILL.
  - If a word is accepted in the same cycle as handoff, it is written to slot 0 of the next frame and idx becomes 1.
  - Without handoff, all state holds indefinitely. No words are dropped and no timeout applies.
- Slots not yet rewritten in a new frame keep their stale contents. pack_out is only meaningful while pack_valid = 1.
- d_in arithmetic: none. Words are stored bit-exact. Only XOR is used, for parity.

## Timing
- Reset values: FSM = FILL, idx = 0, pack_valid = 0, pack_out = 0, frame_cnt = 0, pack_parity = 0.
- d_ready reads 1 in the first cycle after rst deasserts.
- rst has priority over every other input.
- Reset asserted mid-frame or in HOLD discards the partial or pending frame. frame_cnt does not increment.
- Latency: pack_valid rises on the clock edge that accepts the DEPTH-th word, so it is visible the next cycle.
- Minimum spacing is one frame per DEPTH cycles at full throughput: d_valid and pack_ready held at 1 gives zero bubbles.
- pack_valid falls on the edge of the handoff cycle.
- d_ready is combinational from the FSM state and pack_ready. d_ready must not depend on d_valid.

## Configuration
- PUBLIC_TEST_PACK_PARITY_EN defined:
  - A running N-bit XOR accumulator is cleared at the start of each frame and folds in every accepted word.
  - At the HOLD transition, pack_parity is loaded with the XOR of all DEPTH words and held through HOLD.
  - A word accepted in the handoff cycle seeds the new accumulator.
- Macro undefined: the pack_parity port remains present and is tied to 0. No accumulator logic is instantiated.

## Test plan
All scenarios use N=8, DEPTH=4.
- Basic frame: after reset, d_valid=1 with d_in = 0x11, 0x22, 0x33, 0x44 on consecutive cycles, pack_ready=0.
  - Expect pack_valid=1 on the cycle after 0x44, pack_out=0x44332211, d_ready=0.
  - Expect pack_parity=0x44 with the macro, 0x00 without it.
- Backpressure: hold pack_ready=0 for 10 cycles with d_valid=1 and d_in=0xFF.
  - Expect pack_out to stay 0x44332211, no word accepted, frame_cnt=0.
  - Then pulse pack_ready=1 for one cycle: expect frame_cnt=1 and pack_valid=0 the next cycle.
- Simultaneous events: in HOLD, drive pack_ready=1, d_valid=1, d_in=0xA5, then 0xB6, 0xC7, 0xD8.
  - Expect the next frame pack_out=0xD8C7B6A5, presented 3 cycles after the handoff, with frame_cnt=1.
- Gapped input: 0x01, idle, idle, 0x02, 0x03, idle, 0x04.
  - Expect pack_out=0x04030201, with pack_valid rising the cycle after 0x04 is accepted.
- Reset mid-operation: accept 0x10 and 0x20, assert rst for 1 cycle, then send 0x30, 0x40, 0x50, 0x60.
  - Expect pack_out=0x60504030 and frame_cnt=0 before handoff.
- Wrap-around: complete 256 frames with pack_ready tied to 1.
  - Expect frame_cnt to go 255 -> 0, and pack_valid never high for more than 1 cycle per frame.
